// File: rtl/icache_data_ctrl.sv
// rtl/icache_data_ctrl.sv - icache data SRAM refill/fetch sequencer (optional ICACHE_CTRL_PERF_EN perf counters)
module icache_data_ctrl #(
  parameter int SETS       = 16,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  localparam int SW         = $clog2(SETS),
  localparam int NUM_WMASKS = LINE_WIDTH / 8,
  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH,
  localparam int BL         = BEAT_WIDTH / 8,
  localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [SW-1:0]         rd_set,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [LINE_WIDTH-1:0] rd_data,
  output logic                  fill_ready,
  input  logic                  fill_start,
  input  logic [SW-1:0]         fill_set,
  input  logic                  fill_beat_valid,
  input  logic [BEAT_WIDTH-1:0] fill_beat_data,
  output logic                  fill_beat_ready,
  output logic                  fill_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [SW-1:0]         sram_addr0,
  output logic [LINE_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [SW-1:0]         sram_addr1,
  input  logic [LINE_WIDTH-1:0] sram_dout1
`ifdef ICACHE_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_FILL,
    ST_DISARM
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_beat_cnt;
  logic [CW-1:0]         w_beat_cnt_nxt;
  logic [SW-1:0]         r_fill_set;
  logic [SW-1:0]         w_fill_set_nxt;
  logic                  r_rd_valid;
  logic                  r_fill_done;
  logic                  w_busy;
  logic                  w_last_beat;
  logic [NUM_WMASKS-1:0] w_lane_mask;

  // A set is locked from reads from fill_start until the disarm cycle has passed,
  // which guarantees the final write has landed before the line is read.
  assign w_busy      = (r_state == ST_FILL) || (r_state == ST_DISARM);
  assign rd_gnt      = rd_req && !rst && !(w_busy && (rd_set == r_fill_set));
  assign sram_csb1   = !rd_gnt;
  assign sram_addr1  = rd_set;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = sram_dout1;
  assign fill_done   = r_fill_done;

  // Beat k lands in byte lanes [BL*k +: BL]; the beat is replicated across the
  // whole line so the mask alone selects where it is written.
  assign w_last_beat = (r_beat_cnt == CW'(BEATS - 1));
  assign w_lane_mask = {{(NUM_WMASKS - BL){1'b0}}, {BL{1'b1}}} << (32'(r_beat_cnt) * BL);
  assign sram_din0   = {BEATS{fill_beat_data}};
  assign sram_addr0  = r_fill_set;

  // State register plus fill bookkeeping and registered read/fill-done flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_beat_cnt  <= '0;
      r_fill_set  <= '0;
      r_rd_valid  <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_fill_set  <= w_fill_set_nxt;
      r_rd_valid  <= rd_gnt;
      r_fill_done <= (r_state == ST_DISARM);
    end
  end

  // Next-state and port 0 drive; every non-IDLE cycle without a beat is a disarm
  // so the macro never holds a stale write-enable.
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_fill_set_nxt  = r_fill_set;
    fill_ready      = 1'b0;
    fill_beat_ready = 1'b0;
    sram_csb0       = 1'b0;
    sram_web0       = 1'b1;
    sram_wmask0     = '0;
    case (r_state)
      ST_INIT: begin
        w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        fill_ready = 1'b1;
        sram_csb0  = 1'b1;
        if (fill_start) begin
          w_fill_set_nxt = fill_set;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_FILL;
        end
      end
      ST_FILL: begin
        fill_beat_ready = 1'b1;
        if (fill_beat_valid) begin
          sram_web0      = 1'b0;
          sram_wmask0    = w_lane_mask;
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (w_last_beat) begin
            w_state_nxt = ST_DISARM;
          end
        end
      end
      ST_DISARM: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

`ifdef ICACHE_CTRL_PERF_EN
  logic [31:0] r_perf_rd_cnt;
  logic [31:0] r_perf_stall_cnt;

  assign perf_rd_cnt    = r_perf_rd_cnt;
  assign perf_stall_cnt = r_perf_stall_cnt;

  // Free-running grant and stall counters, wrapping naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_rd_cnt    <= '0;
      r_perf_stall_cnt <= '0;
    end else begin
      if (rd_gnt) begin
        r_perf_rd_cnt <= r_perf_rd_cnt + 32'd1;
      end
      if (rd_req && !rd_gnt) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_data_ctrl.sv
// tb/tb_icache_data_ctrl.sv - directed self-checking bench for icache_data_ctrl
module tb_icache_data_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_req = 1'b0;
  logic [3:0]   rd_set = '0;
  logic         rd_gnt;
  logic         rd_valid;
  logic [255:0] rd_data;
  logic         fill_ready;
  logic         fill_start = 1'b0;
  logic [3:0]   fill_set = '0;
  logic         fill_beat_valid = 1'b0;
  logic [63:0]  fill_beat_data = '0;
  logic         fill_beat_ready;
  logic         fill_done;
  logic         sram_csb0;
  logic         sram_web0;
  logic [31:0]  sram_wmask0;
  logic [3:0]   sram_addr0;
  logic [255:0] sram_din0;
  logic         sram_csb1;
  logic [3:0]   sram_addr1;
  logic [255:0] sram_dout1 = '0;
`ifdef ICACHE_CTRL_PERF_EN
  logic [31:0]  perf_rd_cnt;
  logic [31:0]  perf_stall_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  icache_data_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .rd_req          (rd_req),
    .rd_set          (rd_set),
    .rd_gnt          (rd_gnt),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .fill_ready      (fill_ready),
    .fill_start      (fill_start),
    .fill_set        (fill_set),
    .fill_beat_valid (fill_beat_valid),
    .fill_beat_data  (fill_beat_data),
    .fill_beat_ready (fill_beat_ready),
    .fill_done       (fill_done),
    .sram_csb0       (sram_csb0),
    .sram_web0       (sram_web0),
    .sram_wmask0     (sram_wmask0),
    .sram_addr0      (sram_addr0),
    .sram_din0       (sram_din0),
    .sram_csb1       (sram_csb1),
    .sram_addr1      (sram_addr1),
    .sram_dout1      (sram_dout1)
`ifdef ICACHE_CTRL_PERF_EN
    ,
    .perf_rd_cnt     (perf_rd_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  function automatic logic [255:0] init_line(input logic [3:0] s);
    return {8{{28'hA5C30F0, s}}};
  endfunction

  // SRAM macro model: write captured at E lands at E+1, read captured at E
  logic [255:0] mem [16];
  logic [15:0]  written = '0;
  logic         p_we = 1'b0;
  logic [3:0]   p_addr = '0;
  logic [31:0]  p_mask = '0;
  logic [255:0] p_din = '0;

  always @(posedge clk) begin
    if (p_we) begin
      if (!written[p_addr]) begin
        mem[p_addr] = init_line(p_addr);
        written[p_addr] = 1'b1;
      end
      for (int b = 0; b < 32; b++) begin
        if (p_mask[b]) mem[p_addr][8*b +: 8] = p_din[8*b +: 8];
      end
    end
    p_we = 1'b0;
    if (!sram_csb1) sram_dout1 <= written[sram_addr1] ? mem[sram_addr1] : init_line(sram_addr1);
    if (!sram_csb0 && !sram_web0) begin
      p_we = 1'b1;
      p_addr = sram_addr0;
      p_mask = sram_wmask0;
      p_din = sram_din0;
      wr_count++;
    end
  end

  task automatic run_fill(input logic [3:0] s, input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3);
    logic [63:0] bb [4];
    bb = '{b0, b1, b2, b3};
    @(negedge clk); fill_start = 1'b1; fill_set = s;
    @(negedge clk); fill_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fill_beat_valid = 1'b1; fill_beat_data = bb[k];
      @(negedge clk);
    end
    fill_beat_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_req = 1'b1; rd_set = 4'd2;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (fill_ready !== 1'b0) $display("FAIL rst_fill_ready got %h want 0", fill_ready); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid got %h want 0", rd_valid); else pass_cnt++;
    total_cnt++; if (fill_done !== 1'b0) $display("FAIL rst_fill_done got %h want 0", fill_done); else pass_cnt++;
    total_cnt++; if (sram_csb1 !== 1'b1) $display("FAIL rst_csb1 got %h want 1", sram_csb1); else pass_cnt++;
    @(negedge clk); rst = 1'b0; rd_req = 1'b0; #1;
    total_cnt++; if (sram_csb0 !== 1'b0) $display("FAIL init_csb0 got %h want 0", sram_csb0); else pass_cnt++;
    total_cnt++; if (sram_web0 !== 1'b1) $display("FAIL init_web0 got %h want 1", sram_web0); else pass_cnt++;
    total_cnt++; if (sram_wmask0 !== 32'h0) $display("FAIL init_wmask got %h want 0", sram_wmask0); else pass_cnt++;
    total_cnt++; if (fill_ready !== 1'b0) $display("FAIL init_fill_ready got %h want 0", fill_ready); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (fill_ready !== 1'b1) $display("FAIL idle_fill_ready got %h want 1", fill_ready); else pass_cnt++;
    total_cnt++; if (sram_csb0 !== 1'b1) $display("FAIL idle_csb0 got %h want 1", sram_csb0); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL idle_rd_valid got %h want 0", rd_valid); else pass_cnt++;
    total_cnt++; if (fill_done !== 1'b0) $display("FAIL idle_fill_done got %h want 0", fill_done); else pass_cnt++;
  endtask

  task automatic test_fill_b2b();
    logic [63:0]  beats [4];
    logic [31:0]  masks [4];
    logic [255:0] exp_line;
    int wc0;
    beats = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
    masks = '{32'h000000FF, 32'h0000FF00, 32'h00FF0000, 32'hFF000000};
    exp_line = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    @(negedge clk); fill_start = 1'b1; fill_set = 4'd5; rd_req = 1'b1; rd_set = 4'd5; #1;
    total_cnt++; if (rd_gnt !== 1'b1) $display("FAIL start_same_set_gnt got %h want 1", rd_gnt); else pass_cnt++;
    @(negedge clk); fill_start = 1'b0; rd_req = 1'b0; #1;
    total_cnt++; if (rd_valid !== 1'b1) $display("FAIL old_line_valid got %h want 1", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_data !== init_line(4'd5)) $display("FAIL old_line_data got %h want %h", rd_data, init_line(4'd5)); else pass_cnt++;
    wc0 = wr_count;
    for (int k = 0; k < 4; k++) begin
      fill_beat_valid = 1'b1; fill_beat_data = beats[k]; #1;
      total_cnt++; if (sram_wmask0 !== masks[k]) $display("FAIL b2b_wmask%0d got %h want %h", k, sram_wmask0, masks[k]); else pass_cnt++;
      total_cnt++; if ({sram_csb0, sram_web0, fill_beat_ready} !== 3'b001) $display("FAIL b2b_ctl%0d got %b want 001", k, {sram_csb0, sram_web0, fill_beat_ready}); else pass_cnt++;
      total_cnt++; if (sram_addr0 !== 4'd5) $display("FAIL b2b_addr%0d got %h want 5", k, sram_addr0); else pass_cnt++;
      total_cnt++; if (sram_din0 !== {4{beats[k]}}) $display("FAIL b2b_din%0d got %h want %h", k, sram_din0, {4{beats[k]}}); else pass_cnt++;
      @(negedge clk);
    end
    fill_beat_valid = 1'b0; rd_req = 1'b1; rd_set = 4'd5; #1;
    total_cnt++; if ({sram_csb0, sram_web0, sram_wmask0} !== {2'b01, 32'h0}) $display("FAIL disarm_port0 got %b%b %h want 01 0", sram_csb0, sram_web0, sram_wmask0); else pass_cnt++;
    total_cnt++; if (rd_gnt !== 1'b0) $display("FAIL disarm_rd_gnt got %h want 0", rd_gnt); else pass_cnt++;
    total_cnt++; if (fill_done !== 1'b0) $display("FAIL disarm_fill_done got %h want 0", fill_done); else pass_cnt++;
    total_cnt++; if (fill_ready !== 1'b0) $display("FAIL disarm_fill_ready got %h want 0", fill_ready); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (fill_done !== 1'b1) $display("FAIL b2b_fill_done got %h want 1", fill_done); else pass_cnt++;
    total_cnt++; if (rd_gnt !== 1'b1) $display("FAIL done_cycle_gnt got %h want 1", rd_gnt); else pass_cnt++;
    @(negedge clk); rd_req = 1'b0; #1;
    total_cnt++; if (fill_done !== 1'b0) $display("FAIL b2b_fill_done_once got %h want 0", fill_done); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b1) $display("FAIL b2b_rd_valid got %h want 1", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_data !== exp_line) $display("FAIL b2b_line got %h want %h", rd_data, exp_line); else pass_cnt++;
    total_cnt++; if (wr_count - wc0 !== 4) $display("FAIL b2b_writes got %0d want 4", wr_count - wc0); else pass_cnt++;
  endtask

  task automatic test_fill_gaps();
    logic [63:0]  beats [4];
    logic [255:0] exp_line;
    int wc0;
`ifdef ICACHE_CTRL_PERF_EN
    logic [31:0] rd0, st0;
`endif
    beats = '{64'hDEADBEEF00000000, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hCAFEF00D12345678};
    exp_line = {64'hCAFEF00D12345678, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'hDEADBEEF00000000};
    @(negedge clk); fill_start = 1'b1; fill_set = 4'd3;
    @(negedge clk); fill_start = 1'b0;
    wc0 = wr_count;
`ifdef ICACHE_CTRL_PERF_EN
    rd0 = perf_rd_cnt; st0 = perf_stall_cnt;
`endif
    for (int k = 0; k < 4; k++) begin
      fill_beat_valid = 1'b1; fill_beat_data = beats[k]; rd_req = 1'b1; rd_set = 4'd3; #1;
      total_cnt++; if (rd_gnt !== 1'b0) $display("FAIL gap_blk_beat%0d got %h want 0", k, rd_gnt); else pass_cnt++;
      total_cnt++; if (sram_web0 !== 1'b0) $display("FAIL gap_web_beat%0d got %h want 0", k, sram_web0); else pass_cnt++;
      @(negedge clk);
      if (k < 3) begin
        fill_beat_valid = 1'b0; rd_set = 4'd7; #1;
        total_cnt++; if (rd_gnt !== 1'b1) $display("FAIL other_set_gnt%0d got %h want 1", k, rd_gnt); else pass_cnt++;
        total_cnt++; if ({sram_web0, sram_wmask0} !== {1'b1, 32'h0}) $display("FAIL gap1_port0_%0d got %b %h want 1 0", k, sram_web0, sram_wmask0); else pass_cnt++;
        @(negedge clk); rd_set = 4'd3; #1;
        total_cnt++; if (rd_gnt !== 1'b0) $display("FAIL gap_blk2_%0d got %h want 0", k, rd_gnt); else pass_cnt++;
        total_cnt++; if ({sram_web0, sram_wmask0} !== {1'b1, 32'h0}) $display("FAIL gap2_port0_%0d got %b %h want 1 0", k, sram_web0, sram_wmask0); else pass_cnt++;
        total_cnt++; if ({rd_valid, rd_data} !== {1'b1, init_line(4'd7)}) $display("FAIL set7_read%0d got %b %h want 1 %h", k, rd_valid, rd_data, init_line(4'd7)); else pass_cnt++;
        @(negedge clk);
      end
    end
    fill_beat_valid = 1'b0; #1;
    total_cnt++; if (rd_gnt !== 1'b0) $display("FAIL gap_disarm_gnt got %h want 0", rd_gnt); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({fill_done, rd_gnt} !== 2'b11) $display("FAIL gap_done_gnt got %b want 11", {fill_done, rd_gnt}); else pass_cnt++;
    @(negedge clk); rd_req = 1'b0; #1;
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, exp_line}) $display("FAIL gap_line got %b %h want 1 %h", rd_valid, rd_data, exp_line); else pass_cnt++;
    total_cnt++; if (wr_count - wc0 !== 4) $display("FAIL gap_writes got %0d want 4", wr_count - wc0); else pass_cnt++;
`ifdef ICACHE_CTRL_PERF_EN
    total_cnt++; if (perf_stall_cnt - st0 !== 32'd8) $display("FAIL perf_stall got %0d want 8", perf_stall_cnt - st0); else pass_cnt++;
    total_cnt++; if (perf_rd_cnt - rd0 !== 32'd4) $display("FAIL perf_rd got %0d want 4", perf_rd_cnt - rd0); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_midfill();
    logic [255:0] exp_line;
    int wc0;
    exp_line = {64'h9999000099990004, 64'h9999000099990003, 64'h9999000099990002, 64'h9999000099990001};
    @(negedge clk); fill_start = 1'b1; fill_set = 4'd9;
    @(negedge clk); fill_start = 1'b0;
    wc0 = wr_count;
    for (int k = 0; k < 3; k++) begin
      fill_beat_valid = 1'b1; fill_beat_data = 64'h5555AAAA00000000 | 64'(k);
      @(negedge clk);
    end
    fill_beat_valid = 1'b0; rst = 1'b1; #1;
    total_cnt++; if ({sram_csb0, sram_web0, fill_beat_ready} !== 3'b010) $display("FAIL midrst_port0 got %b want 010", {sram_csb0, sram_web0, fill_beat_ready}); else pass_cnt++;
    @(negedge clk); rst = 1'b0; #1;
    total_cnt++; if ({sram_csb0, sram_web0, sram_wmask0, fill_ready} !== {2'b01, 32'h0, 1'b0}) $display("FAIL midrst_init got %b%b %h %b want 01 0 0", sram_csb0, sram_web0, sram_wmask0, fill_ready); else pass_cnt++;
    total_cnt++; if (wr_count - wc0 !== 3) $display("FAIL midrst_writes got %0d want 3", wr_count - wc0); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total_cnt++; if ({fill_done, fill_ready} !== 2'b01) $display("FAIL midrst_no_done%0d got %b want 01", c, {fill_done, fill_ready}); else pass_cnt++;
    end
    run_fill(4'd9, 64'h9999000099990001, 64'h9999000099990002, 64'h9999000099990003, 64'h9999000099990004);
    #1;
    total_cnt++; if (fill_done !== 1'b1) $display("FAIL refill9_done got %h want 1", fill_done); else pass_cnt++;
    rd_req = 1'b1; rd_set = 4'd9;
    @(negedge clk); rd_req = 1'b0; #1;
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, exp_line}) $display("FAIL refill9_line got %b %h want 1 %h", rd_valid, rd_data, exp_line); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); rd_req = 1'b1; rd_set = 4'd0; #1;
    total_cnt++; if (rd_gnt !== 1'b1) $display("FAIL bb_gnt0 got %h want 1", rd_gnt); else pass_cnt++;
    @(negedge clk); rd_set = 4'd1; #1;
    total_cnt++; if ({rd_gnt, rd_valid, rd_data} !== {2'b11, init_line(4'd0)}) $display("FAIL bb_read0 got %b%b %h want 11 %h", rd_gnt, rd_valid, rd_data, init_line(4'd0)); else pass_cnt++;
    @(negedge clk); rd_set = 4'd2; #1;
    total_cnt++; if ({rd_gnt, rd_valid, rd_data} !== {2'b11, init_line(4'd1)}) $display("FAIL bb_read1 got %b%b %h want 11 %h", rd_gnt, rd_valid, rd_data, init_line(4'd1)); else pass_cnt++;
    @(negedge clk); rd_req = 1'b0; #1;
    total_cnt++; if ({rd_valid, rd_data} !== {1'b1, init_line(4'd2)}) $display("FAIL bb_read2 got %b %h want 1 %h", rd_valid, rd_data, init_line(4'd2)); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL bb_valid_drop got %h want 0", rd_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill_b2b();
    test_fill_gaps();
    test_reset_midfill();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
